// File: rtl/aibcr3_dll_scanload.sv
// Scan-chain loader for the DLL delay line: converts a binary delay code into a thermometer
// tap pattern, shifts it MSB-first through SI/SE/SO, captures the old contents and can verify a readback.
module aibcr3_dll_scanload #(
  parameter int NTAP   = 64,
  parameter int CODE_W = 7
) (
  input  logic              CLKIN,
  input  logic              RST,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CODE_W-1:0] cfg_code,
  input  logic              cfg_verify,
  output logic              oSE,
  output logic              oSI,
  input  logic              iSO,
  output logic [NTAP-1:0]   rd_bk,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(NTAP);
  localparam logic [CW-1:0] LAST = CW'(NTAP - 1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, idx, idx_n;
  logic [NTAP-1:0]   pat, pat_n, pat_calc, rdbk_n;
  logic [CODE_W-1:0] code_sat;
  logic              verify, verify_n, err_n, se_n, si_n, done_n, ready_n, last;

  // Thermometer pattern from the requested code; codes beyond the chain length saturate.
  always_comb begin
    code_sat = (cfg_code > CODE_W'(NTAP)) ? CODE_W'(NTAP) : cfg_code;
    for (int i = 0; i < NTAP; i++) begin
      pat_calc[i] = (CODE_W'(i) < code_sat);
    end
  end

  // Next-state logic; the registered SE/SI for a cycle are derived from where the FSM lands,
  // so SE drops on the very edge that completes the last shift.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    pat_n    = pat;
    verify_n = verify;
    err_n    = err;
    rdbk_n   = rd_bk;
    idx      = LAST - cnt;
    last     = (cnt == LAST);
    case (state)
      IDLE: begin
        if (cfg_valid && cfg_ready) begin
          pat_n    = pat_calc;
          verify_n = cfg_verify;
          err_n    = 1'b0;
          cnt_n    = '0;
          state_n  = LOAD;
        end
      end
      LOAD: begin
        rdbk_n[idx] = iSO;
        cnt_n       = last ? '0 : cnt + CW'(1);
        if (last) state_n = verify ? VERIFY : DONE;
      end
      VERIFY: begin
        if (iSO != pat[idx]) err_n = 1'b1;
        cnt_n = last ? '0 : cnt + CW'(1);
        if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    se_n    = (state_n == LOAD) || (state_n == VERIFY);
    idx_n   = LAST - cnt_n;
    si_n    = se_n & pat_n[idx_n];
    done_n  = (state_n == DONE);
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge CLKIN or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= '0;
      verify    <= 1'b0;
      err       <= 1'b0;
      rd_bk     <= '0;
      oSE       <= 1'b0;
      oSI       <= 1'b0;
      done      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pat       <= pat_n;
      verify    <= verify_n;
      err       <= err_n;
      rd_bk     <= rdbk_n;
      oSE       <= se_n;
      oSI       <= si_n;
      done      <= done_n;
      cfg_ready <= ready_n;
    end
  end

endmodule
